// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states,
// datapath select encodings, ALU control codes and data-processing cmd opcodes.
// No ports; imported by alu_decoder and multicycle_ctrl_fsm.
package arm_ctrl_pkg;

  // 4-bit state encoding, FETCH must be zero so reset lands on it.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  // ALUControl
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ALUSrcB
  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Instruction op field
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Data-processing cmd = Funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// ALU decoder (combinational): maps cmd/S to ALUControl, FlagW and NoWrite.
// Ports: ALUOp (decode enable), Funct[5:0] in; ALUControl[1:0], FlagW[1:0], NoWrite out.
// With ALUOp=0 every output is 0 (ADD, no flag write).
module alu_decoder
  import arm_ctrl_pkg::*;
(
  input  logic       ALUOp,
  input  logic [5:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       NoWrite
);

  logic known;  // cmd is one of the supported operations
  logic arith;  // operation produces meaningful C/V flags

  always_comb begin
    ALUControl = ALU_ADD;
    NoWrite    = 1'b0;
    known      = 1'b0;
    arith      = 1'b0;
    if (ALUOp) begin
      case (Funct[4:1])
        CMD_ADD: begin ALUControl = ALU_ADD; known = 1'b1; arith = 1'b1; end
        CMD_SUB: begin ALUControl = ALU_SUB; known = 1'b1; arith = 1'b1; end
        CMD_AND: begin ALUControl = ALU_AND; known = 1'b1; end
        CMD_ORR: begin ALUControl = ALU_ORR; known = 1'b1; end
        CMD_CMP: begin
          ALUControl = ALU_SUB;
          known      = 1'b1;
          arith      = 1'b1;
          NoWrite    = 1'b1;
        end
        default: ALUControl = ALU_ADD;
      endcase
    end
    // Unsupported cmds never touch the flags even if S is set.
    FlagW = known ? {Funct[0], Funct[0] & arith} : 2'b00;
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM main control: Moore FSM (fetch/decode/exec/mem/wb) plus ALU decode.
// Ports: clk, rst (async active-low), Op/Funct/Rd instruction fields in; FlagW, PCS,
// RegW, MemW write requests, NextPC/IRWrite enables and all datapath mux selects out.
// Optional macro DBG_STATE_EN adds output StateDbg[3:0] with the current state.
module multicycle_ctrl_fsm
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
`ifdef DBG_STATE_EN
  ,
  output logic [3:0] StateDbg
`endif
);

  state_e     state_q, state_d;
  logic       no_write_q, no_write_d;
  logic       alu_op;
  logic       dec_no_write;
  logic [1:0] dec_flag_w;
  logic       reg_w_raw, mem_w_raw, next_pc_raw, ir_write_raw, branch_raw;

  alu_decoder u_alu_dec (
    .ALUOp      (alu_op),
    .Funct      (Funct),
    .ALUControl (ALUControl),
    .FlagW      (dec_flag_w),
    .NoWrite    (dec_no_write)
  );

  // Next state and NoWrite capture.
  always_comb begin
    state_d    = state_q;
    no_write_d = no_write_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;  // undefined op: retire with no writes
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR, S_EXECI: begin
        state_d    = S_ALUWB;
        no_write_d = dec_no_write;
      end
      default:  state_d = S_FETCH;  // MEMWB, MEMWR, ALUWB, BRANCH
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      no_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      no_write_q <= no_write_d;
    end
  end

  // Moore decode of the registered state.
  always_comb begin
    next_pc_raw  = 1'b0;
    ir_write_raw = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    branch_raw   = 1'b0;
    alu_op       = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_WDATA;
    ResultSrc    = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        next_pc_raw  = 1'b1;
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w_raw = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        mem_w_raw = 1'b1;
      end
      S_EXECR: alu_op = 1'b1;
      S_EXECI: begin
        alu_op  = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ALUWB: reg_w_raw = ~no_write_q;
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALURESULT;
        branch_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are qualified by rst so nothing is written in a reset cycle,
  // even while the state register already shows FETCH.
  assign NextPC  = next_pc_raw & rst;
  assign IRWrite = ir_write_raw & rst;
  assign RegW    = reg_w_raw & rst;
  assign MemW    = mem_w_raw & rst;
  assign FlagW   = dec_flag_w & {2{rst}};
  assign PCS     = ((Rd == 4'hF) & RegW) | (branch_raw & rst);

  assign ImmSrc  = Op;
  assign RegSrc  = {Op == OP_MEM, Op == OP_BR};

`ifdef DBG_STATE_EN
  assign StateDbg = state_q;
`endif

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control unit of the multicycle ARM processor: a Moore state machine plus an ALU decoder that sequences fetch, decode, execute, memory and writeback for each instruction. It sits directly upstream of the conditional-logic stage and feeds it the unconditioned FlagW, PCS, RegW and MemW. It also drives every datapath mux select and write-enable for the shared-memory multicycle datapath.

## Interface
- No parameters; all encodings are package constants.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]: I, cmd[3:0], S
- Rd  in  4  Instr[15:12]
- FlagW  out  2  flag-write request to conditional logic: [1]=NZ, [0]=CV
- PCS  out  1  PC-write request: `((Rd==4'hF) & RegW) | Branch`
- RegW  out  1  register-file write request
- MemW  out  1  data-memory write request
- NextPC  out  1  unconditional PC update (fetch)
- IRWrite  out  1  instruction-register load
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- ALUSrcA  out  1  0=A register, 1=PC
- ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==2'b10), [1]=(Op==2'b01)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR if Op=01; EXECR if Op=00 & Funct[5]=0; EXECI if Op=00 & Funct[5]=1; BRANCH if Op=10; FETCH if Op=11 (undefined, no writes).
  - MEMADR→MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD→MEMWB→FETCH; MEMWR→FETCH; EXECR/EXECI→ALUWB→FETCH; BRANCH→FETCH.
- Moore outputs (unlisted outputs are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1. MEMWB: ResultSrc=01, RegW=1. MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1. EXECI: ALUSrcB=01, ALUOp=1. ALUWB: ResultSrc=00, RegW=1 unless NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode applies only when ALUOp=1, keyed on cmd=Funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - 1010 CMP → SUB, NoWrite=1.
  - Other cmd → ADD, FlagW=00.
- FlagW[1]=S; FlagW[0]=S & (ADD|SUB|CMP).
- With ALUOp=0: ALUControl=00, FlagW=00, so flags only update in EXECR/EXECI.
- NoWrite is latched in EXECR/EXECI and consumed in ALUWB.

## Timing
- Cycles per instruction, FETCH inclusive: branch 3, data-processing 4, STR 4, LDR 5, undefined 2.
- All outputs are registered-state decodes; no combinational path from Op/Funct/Rd to write enables, except PCS (Rd term) and the ALU decode during execute states.
- Reset (rst=0): state←FETCH immediately, NoWrite←0, and IRWrite, NextPC, RegW, MemW, PCS and FlagW are forced 0. Selects hold FETCH values: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00.
- First fetch occurs on the first rising edge after rst deasserts.
- Reset asserted mid-instruction aborts it; no partial write is issued in the reset cycle.

## Configuration
- DBG_STATE_EN
  - Defined: adds output StateDbg (4 bits) carrying the current state encoding.
  - Undefined: the port is absent and behaviour is otherwise identical.

## Structure
- Package arm_ctrl_pkg holds:
  - the state enum (4-bit encoding, FETCH=0);
  - ALUControl, ALUSrcB and ResultSrc encodings;
  - cmd opcode constants.
- Sub-module alu_decoder (combinational): inputs ALUOp and Funct; outputs ALUControl, FlagW and NoWrite.

## Test plan
- Reset low for 3 cycles, then high → during reset all enables 0; the first cycle after release is FETCH with IRWrite=1 and NextPC=1.
- ADDS R1,R2,R3 (Op=00, Funct=001001) → state sequence FETCH,DECODE,EXECR,ALUWB; FlagW=11 only in EXECR; RegW=1 in ALUWB.
- CMP immediate (Funct=110101) → EXECI, ALUControl=01, FlagW=11; ALUWB with RegW=0.
- LDR (Op=01, Funct[0]=1) → 5-cycle sequence ending MEMWB with ResultSrc=01; Rd=15 gives PCS=1 in MEMWB.
- STR (Funct[0]=0) → MEMWR with MemW=1 and AdrSrc=1; then FETCH.
- Branch (Op=10) → BRANCH with PCS=1 and RegW=0. Reset asserted in BRANCH → PCS drops to 0 the same cycle and state returns to FETCH.
